// File: rtl/boot_rom_bus_adapter_if.sv
// Request/response bus between a core fetch/load port and the boot ROM adapter.
// The master drives requests and consumes responses; the slave grants and responds.
interface boot_rom_bus_adapter_if;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        rready_i;

    modport master (
        output req_i, addr_i, we_i, rready_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, rready_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/boot_rom_bus_adapter.sv
// Boot ROM bus adapter: decodes byte addresses into ROM word reads, flags illegal
// accesses, and returns responses in grant order through a credit-limited buffer.

module boot_rom_bus_adapter_chk (
    input logic CLK,
    input logic RST,
    input logic push,
    input logic full
);
    // The grant credit limit must make a push into a full buffer impossible.
    assert property (@(posedge CLK) disable iff (RST) !(push && full))
        else $error("boot_rom_bus_adapter: push into full response buffer");
endmodule

module boot_rom_bus_adapter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0008_0000,
    parameter int          ROM_WORDS  = 548,
    parameter int          ROM_AW     = 10,
    parameter int          RESP_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    boot_rom_bus_adapter_if.slave bus,
    output logic                  rom_csn_o,
    output logic [ROM_AW-1:0]     rom_a_o,
    input  logic [31:0]           rom_q_i,
    output logic [7:0]            err_cnt_o
);
    localparam int          PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int          CNT_W     = $clog2(RESP_DEPTH + 1);
    localparam int          OCC_W     = CNT_W + 1;
    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS) << 2;

    logic [31:0]       off_s;
    logic              legal_s;
    logic [OCC_W-1:0]  occ_s;
    logic              gnt_s;
    logic              rom_cs_s;

    logic              pend_vld_r;
    logic              pend_err_r;
    logic [31:0]       pend_data_s;

    logic [31:0]       fifo_data_r [RESP_DEPTH];
    logic              fifo_err_r  [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  fifo_cnt_r;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_pop_s;

    logic              rvalid_s;
    logic              err_s;
    logic [31:0]       rdata_s;

    logic [ROM_AW-1:0] rom_a_r;
    logic [7:0]        err_cnt_r;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(RESP_DEPTH - 1)) begin
            next_ptr = {PTR_W{1'b0}};
        end else begin
            next_ptr = ptr + PTR_W'(1);
        end
    endfunction

    // Address decode, legality check and credit-limited grant.
    always_comb begin
        off_s   = bus.addr_i - BASE_ADDR;
        legal_s = (bus.we_i == 1'b0) && (bus.addr_i[1:0] == 2'b00) && (off_s < ROM_BYTES);
        occ_s   = OCC_W'(fifo_cnt_r) + OCC_W'(pend_vld_r);
        // Same-cycle pops are deliberately not credited back to keep gnt shallow.
        gnt_s    = bus.req_i && !RST && (occ_s < OCC_W'(RESP_DEPTH));
        rom_cs_s = gnt_s && legal_s;
    end

    // Response selection: buffered head first, otherwise bypass the pending stage.
    always_comb begin
        fifo_empty_s = (fifo_cnt_r == {CNT_W{1'b0}});
        fifo_full_s  = (fifo_cnt_r == CNT_W'(RESP_DEPTH));
        pend_data_s  = pend_err_r ? 32'h0000_0000 : rom_q_i;
        if (!fifo_empty_s) begin
            rvalid_s = 1'b1;
            rdata_s  = fifo_data_r[rd_ptr_r];
            err_s    = fifo_err_r[rd_ptr_r];
        end else if (pend_vld_r) begin
            rvalid_s = 1'b1;
            rdata_s  = pend_data_s;
            err_s    = pend_err_r;
        end else begin
            rvalid_s = 1'b0;
            rdata_s  = 32'h0000_0000;
            err_s    = 1'b0;
        end
        pop_s      = rvalid_s && bus.rready_i;
        fifo_pop_s = pop_s && !fifo_empty_s;
        // ROM output is only stable for one cycle, so pending must land now unless bypassed.
        push_s     = pend_vld_r && !(fifo_empty_s && pop_s);
    end

    // Pending stage: one-cycle slot matching the ROM read latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_vld_r <= 1'b0;
            pend_err_r <= 1'b0;
        end else begin
            pend_vld_r <= gnt_s;
            pend_err_r <= !legal_s;
        end
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_data_r[i] <= 32'h0000_0000;
                fifo_err_r[i]  <= 1'b0;
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_data_r[wr_ptr_r] <= pend_data_s;
                fifo_err_r[wr_ptr_r]  <= pend_err_r;
                wr_ptr_r              <= next_ptr(wr_ptr_r);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, fifo_pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Hold the last driven ROM address between accesses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rom_a_r <= {ROM_AW{1'b0}};
        end else if (rom_cs_s) begin
            rom_a_r <= off_s[ROM_AW+1:2];
        end else begin
            rom_a_r <= rom_a_r;
        end
    end

    // Saturating count of error responses actually delivered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_cnt_r <= 8'h00;
        end else if (pop_s && err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.gnt_o    = gnt_s;
    assign bus.rvalid_o = rvalid_s;
    assign bus.rdata_o  = rdata_s;
    assign bus.err_o    = err_s;
    assign rom_csn_o    = !rom_cs_s;
    assign rom_a_o      = rom_cs_s ? off_s[ROM_AW+1:2] : rom_a_r;
    assign err_cnt_o    = err_cnt_r;

    boot_rom_bus_adapter_chk u_chk (
        .CLK  (CLK),
        .RST  (RST),
        .push (push_s),
        .full (fifo_full_s)
    );
endmodule

// File: doc/boot_rom_bus_adapter.md
Name: boot_rom_bus_adapter

Overview:
- Bus-side front end for the boot ROM.
- Accepts core fetch/load requests on a req/gnt/rvalid bus and translates byte addresses into ROM word indices.
- Drives the ROM's chip-select and address, captures the ROM's one-cycle-latency read data, and returns it to the requester through a small response buffer that supports rready backpressure.
- Detects illegal accesses (write, misaligned, out of range) and returns an error response without touching the ROM.

Parameters:
- BASE_ADDR, 32'h0008_0000, byte base address of the ROM window.
- ROM_WORDS, 548, number of valid 32-bit words in the ROM.
- ROM_AW, 10, ROM word-address width.
- RESP_DEPTH, 2, response FIFO entries (≥1).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- req_i  in  1  request valid.
- addr_i  in  32  byte address.
- we_i  in  1  write enable (writes are illegal).
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  response data.
- err_o  out  1  response is an error.
- rready_i  in  1  requester consumes the response.
- rom_csn_o  out  1  ROM chip select, active low.
- rom_a_o  out  ROM_AW  ROM word address.
- rom_q_i  in  32  ROM data, valid the cycle after rom_csn_o is low.
- err_cnt_o  out  8  saturating count of error responses issued.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While RST is high, all state clears: FIFO empty, pending stage invalid, err_cnt_o=0. Consequently rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, rom_csn_o=1, rom_a_o=0. Reset mid-operation drops all in-flight and buffered responses.
- Offset: off = addr_i - BASE_ADDR, computed with 32-bit unsigned wrap.
- Legality: a request is legal iff all of the following hold; otherwise it is illegal:
  - we_i=0
  - addr_i[1:0]=0
  - off < ROM_WORDS*4 (unsigned; addresses below BASE_ADDR wrap large and are therefore illegal).
- Occupancy: occ = FIFO count + pending valid.
- Grant: gnt_o = req_i && (occ < RESP_DEPTH). gnt_o is combinational. It conservatively ignores a same-cycle pop, so a full buffer stalls for one cycle even if rready_i=1.
- Accepted legal request (cycle T): rom_csn_o=0 and rom_a_o=off[ROM_AW+1:2] in cycle T, combinationally from addr_i. In every other cycle rom_csn_o=1 and rom_a_o holds its last driven value (registered copy).
- Accepted illegal request: rom_csn_o stays 1. The request still enters the pending stage with err=1, giving the same latency as a legal request.
- Pending stage (cycle T+1): pending valid. Data is rom_q_i for a legal request, 32'h0 for an illegal one.
- Response mux:
  - FIFO non-empty: rvalid_o=1 and rdata_o/err_o come from the FIFO head.
  - FIFO empty and pending valid: rvalid_o=1 and rdata_o/err_o come from the pending stage (bypass). Best-case latency is 1 cycle after grant.
  - Otherwise: rvalid_o=0, rdata_o=0, err_o=0.
- Pop: rvalid_o && rready_i.
- Pending capture: at the end of cycle T+1, pending is pushed into the FIFO unless it was popped directly via bypass. Capture in that cycle is mandatory, because the ROM output changes after the next grant.
- Ordering: responses are strictly in grant order. A simultaneous push and pop on the FIFO is allowed at any occupancy. Push when full cannot occur because grant is credit-limited; an assertion checks this.
- Back-to-back: with rready_i held 1, a legal request is granted every cycle and returns rvalid_o every cycle at throughput 1.
- err_cnt_o: increments by 1 when an error response is popped. It saturates at 8'hFF.
- rready_i while rvalid_o=0 is ignored.

Test Plan:
- Single legal read: addr_i=32'h0008_0010, rready_i=1 → in the grant cycle rom_csn_o=0 and rom_a_o=4; one cycle later rvalid_o=1, rdata_o=ROM word 4, err_o=0.
- Back-to-back: 4 consecutive reads at 0x0008_0000..0x0008_000C with rready_i=1 → gnt_o high 4 cycles; rvalid_o high 4 consecutive cycles, starting 1 cycle after the first grant, with words 0..3 in order.
- Backpressure: rready_i=0 with 3 consecutive requests → first 2 granted, third held with gnt_o=0. Raise rready_i → words returned in order; the third request is granted the cycle after occ drops below 2, and no ROM data is lost.
- Illegal accesses, each → rom_csn_o stays 1; response rvalid_o=1, err_o=1, rdata_o=0 after 1 cycle; err_cnt_o ends at 4:
  - we_i=1
  - addr 0x0008_0002
  - addr 0x0008_0890 (word 548)
  - addr 0x0007_FFFC
- Boundary: addr 0x0008_088C (word 547) → legal, rom_a_o=547. Separately, 256 error responses → err_cnt_o saturates at 8'hFF.
- Reset mid-flight: fill FIFO with rready_i=0, pulse RST asynchronously → rvalid_o=0, rom_csn_o=1, err_cnt_o=0 immediately; the next request after reset behaves as in the single-read scenario.
